// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for mem_stage_stack
package mem_stage_pkg;

  // Default build parameters for the stage
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 12;

  // Wide stack ops occupy the stage for two beats
  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } state_t;

  // Beat-select word offsets relative to the free-slot stack pointer
  localparam int unsigned POP_LO_OFS  = 1;  // pop reads SP+1 first (low word)
  localparam int unsigned POP_HI_OFS  = 2;  // wide pop second beat reads SP+2 (high word)
  localparam int unsigned PUSH_LO_OFS = 1;  // wide push second beat writes SP-1 (low word)

endpackage

// File: rtl/stack_ptr_unit.sv
// rtl/stack_ptr_unit.sv - stack pointer register with optional bound check (STACK_GUARD_EN)
module stack_ptr_unit import mem_stage_pkg::*; #(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SP_RESET    = 2**ADDR_W - 1,
  parameter int unsigned STACK_LIMIT = 2**ADDR_W - 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chk_push,
  input  logic              chk_two,
  input  logic              upd_en,
  input  logic              upd_push,
  input  logic              upd_two,
  input  logic              err_set,
  output logic              legal,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] step;

  // Next SP: descend on push, ascend on pop, by one or two words
  always_comb begin
    step = upd_two ? ADDR_W'(2) : ADDR_W'(1);
    sp_d = sp_q;
    if (upd_en) begin
      sp_d = upd_push ? (sp_q - step) : (sp_q + step);
    end
  end

  // SP register, returns to the top of the stack region on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sp_q <= ADDR_W'(SP_RESET);
    else        sp_q <= sp_d;
  end

  assign sp = sp_q;

`ifdef STACK_GUARD_EN
  localparam logic [ADDR_W:0] LIM_X = (ADDR_W+1)'(STACK_LIMIT);
  localparam logic [ADDR_W:0] TOP_X = (ADDR_W+1)'(SP_RESET);

  logic            err_q, err_d;
  logic [ADDR_W:0] sp_x, n_x;

  // Bounds evaluated one bit wider so no comparison can wrap
  always_comb begin
    sp_x  = {1'b0, sp_q};
    n_x   = chk_two ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    if (chk_push) legal = (sp_x + (ADDR_W+1)'(1)) >= (n_x + LIM_X);
    else          legal = (sp_x + n_x) <= TOP_X;
    err_d = err_q | err_set;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign stack_err = err_q;
`else
  logic unused_guard;
  assign unused_guard = ^{chk_push, chk_two, err_set, (STACK_LIMIT != 0)};
  assign legal        = 1'b1;
  assign stack_err    = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_stack.sv
// rtl/mem_stage_stack.sv - pipeline memory stage with load/store and hardware stack; bound checks under STACK_GUARD_EN
module mem_stage_stack import mem_stage_pkg::*; #(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SP_RESET    = 2**ADDR_W - 1,
  parameter int unsigned STACK_LIMIT = 2**ADDR_W - 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                stack_op,
  input  logic                push_pop,
  input  logic                wide,
  input  logic                mem_to_reg,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                out_valid,
  output logic [2*DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0]   sp,
  output logic                stack_err
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0] wb_q, wb_d;
  logic [DATA_W-1:0]   lo_q, lo_d, alu_q, alu_d;
  logic                push_q, push_d, mrg_q, mrg_d, bad_q, bad_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa, rd_addr;
  logic [DATA_W-1:0]   mem_wd, rd_word;
  logic                legal, upd_en, upd_push, upd_two, err_set;

  assign in_ready = (state_q == IDLE);

  stack_ptr_unit #(
    .ADDR_W      (ADDR_W),
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk       (clk),
    .reset     (reset),
    .chk_push  (push_pop),
    .chk_two   (wide),
    .upd_en    (upd_en),
    .upd_push  (upd_push),
    .upd_two   (upd_two),
    .err_set   (err_set),
    .legal     (legal),
    .sp        (sp),
    .stack_err (stack_err)
  );

  // Read address for the current beat, kept apart from the main decode to avoid a comb loop
  always_comb begin
    rd_addr = addr;
    if (state_q == BEAT2) begin
      rd_addr = push_q ? (sp - ADDR_W'(PUSH_LO_OFS)) : (sp + ADDR_W'(POP_HI_OFS));
    end else if (stack_op) begin
      rd_addr = push_pop ? sp : (sp + ADDR_W'(POP_LO_OFS));
    end
  end

  assign rd_word = mem[rd_addr];

  // Beat decode: memory write, SP update, latched wide-op context and write-back value
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    wb_d        = wb_q;
    lo_d        = lo_q;
    alu_d       = alu_q;
    push_d      = push_q;
    mrg_d       = mrg_q;
    bad_d       = bad_q;
    mem_we      = 1'b0;
    mem_wa      = sp;
    mem_wd      = '0;
    upd_en      = 1'b0;
    upd_push    = 1'b0;
    upd_two     = 1'b0;
    err_set     = 1'b0;
    if (state_q == BEAT2) begin
      state_d     = IDLE;
      out_valid_d = 1'b1;
      if (push_q) begin
        mem_wa = sp - ADDR_W'(PUSH_LO_OFS);
        mem_wd = lo_q;
        mem_we = !bad_q;
      end
      upd_en   = !bad_q;
      upd_push = push_q;
      upd_two  = 1'b1;
      wb_d     = bad_q ? '0 : (mrg_q ? {rd_word, lo_q} : {{DATA_W{1'b0}}, alu_q});
    end else if (in_valid) begin
      if (stack_op) begin
        err_set = !legal;
        if (push_pop) begin
          mem_wa = sp;
          mem_wd = wide ? write_data[2*DATA_W-1:DATA_W] : write_data[DATA_W-1:0];
          mem_we = legal;
        end
        if (wide) begin
          state_d = BEAT2;
          push_d  = push_pop;
          mrg_d   = mem_to_reg;
          bad_d   = !legal;
          alu_d   = alu_data;
          lo_d    = push_pop ? write_data[DATA_W-1:0] : rd_word;
        end else begin
          out_valid_d = 1'b1;
          upd_en      = legal;
          upd_push    = push_pop;
          wb_d        = !legal ? '0 :
                        (mem_to_reg ? {{DATA_W{1'b0}}, rd_word} : {{DATA_W{1'b0}}, alu_data});
        end
      end else begin
        out_valid_d = 1'b1;
        mem_we      = mem_write;
        mem_wa      = addr;
        mem_wd      = write_data[DATA_W-1:0];
        wb_d        = (mem_to_reg && (mem_read || mem_write)) ? {{DATA_W{1'b0}}, rd_word}
                                                              : {{DATA_W{1'b0}}, alu_data};
      end
    end
  end

  // Data memory: contents survive reset, no write while reset is held
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_wa] <= mem_wd;
  end

  // Stage state, registered outputs and wide-op context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      lo_q        <= '0;
      alu_q       <= '0;
      push_q      <= 1'b0;
      mrg_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wb_q        <= wb_d;
      lo_q        <= lo_d;
      alu_q       <= alu_d;
      push_q      <= push_d;
      mrg_q       <= mrg_d;
      bad_q       <= bad_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wb_data   = wb_q;

endmodule
